fir_datapath: RTL and testbench



---
 rtl/fir_datapath_if.sv | 35 +++
 rtl/fir_datapath.sv | 101 ++++++++++
 tb/tb_fir_datapath.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fir_datapath_if.sv
// -----------------------------------------------------------------------------
// fir_datapath_if
//   Micro-operation bus between the FIR filter controller and the register
//   file / ALU datapath.
//
//   op          controller -> datapath  opcode (NOP/COPY/LOAD1/LOAD2/ADD/SUB/MUL)
//   src1, src2  controller -> datapath  operand register indices
//   dest        controller -> datapath  destination register index
//   ext_data1   controller -> datapath  incoming sample (LOAD1)
//   ext_data2   controller -> datapath  incoming coefficient (LOAD2)
//   outreg_data datapath -> controller  current contents of R0 (filter output)
//   overflow    datapath -> controller  registered overflow of the last op
// -----------------------------------------------------------------------------
interface fir_datapath_if #(
  parameter int DATA_W = 16
);
  logic [2:0]        op;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic [3:0]        dest;
  logic [DATA_W-1:0] ext_data1;
  logic [DATA_W-1:0] ext_data2;
  logic [DATA_W-1:0] outreg_data;
  logic              overflow;

  modport master (
    output op, src1, src2, dest, ext_data1, ext_data2,
    input  outreg_data, overflow
  );

  modport slave (
    input  op, src1, src2, dest, ext_data1, ext_data2,
    output outreg_data, overflow
  );
endinterface

// File: rtl/fir_datapath.sv
// -----------------------------------------------------------------------------
// fir_datapath
//   Register-file / ALU datapath of the FIR filter engine. Executes one
//   micro-operation per clock on a 16 x DATA_W unsigned register file and
//   reports a registered overflow flag (carry, borrow or product high half).
//
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous active-high reset: clears every register and overflow
//   bus   fir_datapath_if.slave: op/src1/src2/dest/ext_data1/ext_data2 in,
//         outreg_data (= R0) and overflow out
// -----------------------------------------------------------------------------
module fir_datapath #(
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  fir_datapath_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_COPY  = 3'b001,
    OP_LOAD1 = 3'b010,
    OP_LOAD2 = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  op_e                 op;
  logic [DATA_W-1:0]   regs [16];
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   result;
  logic                wr_en;
  logic                ovf;
  logic                overflow_q;

  assign op = op_e'(bus.op);

  // Operands come straight from the pre-edge register contents, so aliased
  // src/dest (e.g. ADD R3,R3->R3) naturally uses the old value.
  assign opa = regs[bus.src1];
  assign opb = regs[bus.src2];

  // One extra bit captures carry (ADD) and borrow (SUB: top bit set iff A < B).
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};
  assign prod = {{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    wr_en  = 1'b0;
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_COPY:  begin wr_en = 1'b1; result = opa;           end
      OP_LOAD1: begin wr_en = 1'b1; result = bus.ext_data1; end
      OP_LOAD2: begin wr_en = 1'b1; result = bus.ext_data2; end
      OP_ADD: begin
        wr_en  = 1'b1;
        result = sum[DATA_W-1:0];
        ovf    = sum[DATA_W];
      end
      OP_SUB: begin
        wr_en  = 1'b1;
        result = diff[DATA_W-1:0];
        ovf    = diff[DATA_W];
      end
      OP_MUL: begin
        wr_en  = 1'b1;
        result = prod[DATA_W-1:0];
        ovf    = |prod[2*DATA_W-1:DATA_W];
      end
      default: ; // NOP and reserved opcode: no write, overflow cleared
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values,
  // which is what makes a same-cycle read of the destination see the old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is built from flops and must read as zero
      // after reset, so it is cleared explicitly rather than left to power-up.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= ovf;
      if (wr_en) regs[bus.dest] <= result;
    end
  end

  assign bus.outreg_data = regs[0];
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fir_datapath.sv
// -----------------------------------------------------------------------------
// tb_fir_datapath
//   Self-checking bench for fir_datapath: directed scenarios followed by a
//   randomized op stream, compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fir_datapath;

  localparam int DATA_W = 16;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] COPY  = 3'b001;
  localparam logic [2:0] LOAD1 = 3'b010;
  localparam logic [2:0] LOAD2 = 3'b011;
  localparam logic [2:0] ADD   = 3'b100;
  localparam logic [2:0] SUB   = 3'b101;
  localparam logic [2:0] MUL   = 3'b110;
  localparam logic [2:0] RSVD  = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_datapath_if #(.DATA_W(DATA_W)) bus ();

  fir_datapath #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  // Reference model: register values as plain integers.
  int model_regs [16];
  int model_ovf;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_apply(input logic r, input logic [2:0] o, input int s1, input int s2,
                             input int d, input int e1, input int e2);
    int     a;
    int     b;
    int     res;
    bit     wr;
    longint p;
    if (r) begin
      for (int i = 0; i < 16; i++) model_regs[i] = 0;
      model_ovf = 0;
      return;
    end
    a   = model_regs[s1];
    b   = model_regs[s2];
    wr  = 1'b1;
    res = 0;
    model_ovf = 0;
    case (o)
      COPY:  res = a;
      LOAD1: res = e1;
      LOAD2: res = e2;
      ADD: begin
        res = (a + b) % 65536;
        model_ovf = (a + b > 65535) ? 1 : 0;
      end
      SUB: begin
        res = (a - b + 65536) % 65536;
        model_ovf = (a < b) ? 1 : 0;
      end
      MUL: begin
        p = longint'(a) * longint'(b);
        res = int'(p % 65536);
        model_ovf = (p > 65535) ? 1 : 0;
      end
      default: wr = 1'b0;
    endcase
    if (wr) model_regs[d] = res;
  endtask

  // Present one op, clock it, then compare R0 and overflow with the model.
  task automatic step(input string tag, input logic r, input logic [2:0] o,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                      input logic [15:0] e1, input logic [15:0] e2);
    rst           = r;
    bus.op        = o;
    bus.src1      = s1;
    bus.src2      = s2;
    bus.dest      = d;
    bus.ext_data1 = e1;
    bus.ext_data2 = e2;
    @(posedge clk);
    #1;
    model_apply(r, o, int'(s1), int'(s2), int'(d), int'(e1), int'(e2));
    rst = 1'b0;
    check({tag, ".out"}, bus.outreg_data, 16'(model_regs[0]));
    check({tag, ".ovf"}, {15'd0, bus.overflow}, 16'(model_ovf));
  endtask

  // Move register k to R0 so its value becomes observable.
  task automatic peek(input string tag, input logic [3:0] k, input logic [15:0] exp);
    step({tag, ".copy"}, 1'b0, COPY, k, 4'd0, 4'd0, 16'h0, 16'h0);
    check(tag, bus.outreg_data, exp);
  endtask

  initial begin
    logic [2:0]  o;
    logic [15:0] e1;
    logic [15:0] e2;

    bus.op = NOP; bus.src1 = '0; bus.src2 = '0; bus.dest = '0;
    bus.ext_data1 = '0; bus.ext_data2 = '0;
    for (int i = 0; i < 16; i++) model_regs[i] = 0;
    model_ovf = 0;

    // Power-up reset.
    step("rst0", 1'b1, NOP, 0, 0, 0, 0, 0);
    step("rst1", 1'b1, NOP, 0, 0, 0, 0, 0);
    check("reset_out", bus.outreg_data, 16'h0000);
    check("reset_ovf", {15'd0, bus.overflow}, 16'h0000);

    // Reset wins over a concurrent ADD and clears preloaded registers.
    step("pre0", 1'b0, LOAD1, 0, 0, 4'd0, 16'h1234, 0);
    check("pre_r0", bus.outreg_data, 16'h1234);
    step("pre5", 1'b0, LOAD2, 0, 0, 4'd5, 0, 16'h00FF);
    step("rst_add", 1'b1, ADD, 4'd0, 4'd5, 4'd0, 0, 0);
    check("rst_add_out", bus.outreg_data, 16'h0000);
    check("rst_add_ovf", {15'd0, bus.overflow}, 16'h0000);
    peek("rst_r5", 4'd5, 16'h0000);

    // Load / copy.
    step("ld1", 1'b0, LOAD1, 0, 0, 4'd1, 16'h0010, 16'hAAAA);
    step("ld2", 1'b0, LOAD2, 0, 0, 4'd2, 16'h5555, 16'h0003);
    step("cp", 1'b0, COPY, 4'd2, 0, 4'd0, 0, 0);
    check("copy_r0", bus.outreg_data, 16'h0003);

    // Multiply / add chain.
    step("mul", 1'b0, MUL, 4'd1, 4'd2, 4'd3, 0, 0);
    check("mul_ovf", {15'd0, bus.overflow}, 16'h0000);
    peek("mul_r3", 4'd3, 16'h0030);
    step("add", 1'b0, ADD, 4'd3, 4'd3, 4'd0, 0, 0);
    check("chain_r0", bus.outreg_data, 16'h0060);

    // ADD carry out, then NOP clears overflow.
    step("ofa1", 1'b0, LOAD1, 0, 0, 4'd1, 16'hFFFF, 0);
    step("ofa2", 1'b0, LOAD2, 0, 0, 4'd2, 0, 16'h0002);
    step("ofadd", 1'b0, ADD, 4'd1, 4'd2, 4'd4, 0, 0);
    check("add_carry", {15'd0, bus.overflow}, 16'h0001);
    step("ofnop", 1'b0, NOP, 4'd1, 4'd2, 4'd4, 0, 0);
    check("nop_clears", {15'd0, bus.overflow}, 16'h0000);
    peek("add_r4", 4'd4, 16'h0001);

    // MUL with non-zero high half.
    step("ofm1", 1'b0, LOAD1, 0, 0, 4'd1, 16'h0100, 0);
    step("ofm2", 1'b0, LOAD1, 0, 0, 4'd2, 16'h0100, 0);
    step("ofmul", 1'b0, MUL, 4'd1, 4'd2, 4'd5, 0, 0);
    check("mul_ovf1", {15'd0, bus.overflow}, 16'h0001);
    peek("mul_r5", 4'd5, 16'h0000);

    // SUB borrow and no-borrow.
    step("sb1", 1'b0, LOAD1, 0, 0, 4'd1, 16'h0003, 0);
    step("sb2", 1'b0, LOAD1, 0, 0, 4'd2, 16'h0005, 0);
    step("sub_a", 1'b0, SUB, 4'd1, 4'd2, 4'd6, 0, 0);
    check("sub_borrow", {15'd0, bus.overflow}, 16'h0001);
    peek("sub_r6a", 4'd6, 16'hFFFE);
    step("sub_b", 1'b0, SUB, 4'd2, 4'd1, 4'd6, 0, 0);
    check("sub_noborrow", {15'd0, bus.overflow}, 16'h0000);
    peek("sub_r6b", 4'd6, 16'h0002);

    // Aliasing and reserved opcode.
    step("al1", 1'b0, LOAD1, 0, 0, 4'd7, 16'h4000, 0);
    step("alias", 1'b0, ADD, 4'd7, 4'd7, 4'd7, 0, 0);
    check("alias_ovf", {15'd0, bus.overflow}, 16'h0000);
    step("rsvd", 1'b0, RSVD, 4'd7, 4'd7, 4'd7, 16'h1111, 16'h2222);
    check("rsvd_ovf", {15'd0, bus.overflow}, 16'h0000);
    peek("alias_r7", 4'd7, 16'h8000);

    // Randomized stream with a mid-sequence reset.
    for (int i = 0; i < 400; i++) begin
      o  = 3'($urandom_range(0, 7));
      e1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      e2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      step("rand", (i == 200) ? 1'b1 : 1'b0, o,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)), e1, e2);
      if (i % 8 == 7) begin
        step("rand_peek", 1'b0, COPY, 4'($urandom_range(1, 15)), 4'd0, 4'd0, 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
